// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the ifetch32 instruction fetch unit.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP           = 32'd4;
    localparam logic [XLEN-1:0] PC_READ_OFS       = 32'd8;
    localparam logic [XLEN-1:0] LINK_OFS          = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'hE1A0_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] word;
        logic [XLEN-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/pfbuf32.sv
// One-entry prefetch buffer holding a fetched word and its address.
module pfbuf32
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full
);

    // Flush beats push; a push alongside a pop replaces the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            head <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            head <= push_entry;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch32.sv
// Instruction fetch / PC sequencer with a one-entry prefetch buffer and branch redirect.
// Optional macro IFETCH32_BL_LINK_EN enables the r14 link write strobe for branch-with-link.
module ifetch32
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_out,
    input  logic        ib,
    input  logic [31:0] bv,
    input  logic        bl,
    output logic        link_we,
    output logic [31:0] link_data
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  issue_addr_q, issue_addr_d;
    logic [31:0]  instr_d, addr_d;
    logic         valid_d, req_d;

    logic         ack, fire, branch, issue_take, word_in;
    logic [31:0]  target;
    fetch_entry_t ack_entry, buf_head;
    logic         buf_full, buf_push, buf_pop, buf_flush, buf_next;

    assign ack        = imem_req & imem_ack;
    assign fire       = instr_valid & instr_ready;
    assign branch     = fire & ib;
    assign issue_take = ~instr_valid | fire;
    assign word_in    = ack & (state_q == REQ);
    assign target     = issue_addr_q + PC_READ_OFS + bv;
    assign ack_entry  = '{word: imem_rdata, addr: imem_addr};

    pfbuf32 u_pfbuf (
        .clk        (clk),
        .reset      (reset),
        .push       (buf_push),
        .push_entry (ack_entry),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .head       (buf_head),
        .full       (buf_full)
    );

    // Next-state, issue/buffer steering and request generation.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        issue_addr_d = issue_addr_q;
        instr_d      = instr_out;
        valid_d      = instr_valid;
        req_d        = imem_req;
        addr_d       = imem_addr;
        buf_push     = 1'b0;
        buf_pop      = 1'b0;
        buf_flush    = 1'b0;
        buf_next     = buf_full;

        if (branch) begin
            buf_flush  = 1'b1;
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            fetch_pc_d = target;
            // An unacknowledged request must complete at its original address.
            if (imem_req & ~imem_ack) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = target;
            end
        end else begin
            if (issue_take) begin
                if (buf_full) begin
                    valid_d      = 1'b1;
                    instr_d      = buf_head.word;
                    issue_addr_d = buf_head.addr;
                    buf_pop      = 1'b1;
                    buf_push     = word_in;
                end else if (word_in) begin
                    valid_d      = 1'b1;
                    instr_d      = imem_rdata;
                    issue_addr_d = imem_addr;
                end else begin
                    valid_d      = 1'b0;
                end
            end else begin
                buf_push = word_in;
            end
            buf_next = (buf_full & ~buf_pop) | buf_push;

            case (state_q)
                REQ: begin
                    req_d = 1'b1;
                    if (word_in) begin
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                        if (valid_d & buf_next) begin
                            state_d = HOLD;
                            req_d   = 1'b0;
                        end else begin
                            addr_d = fetch_pc_q + PC_STEP;
                        end
                    end
                end
                HOLD: begin
                    if (~(valid_d & buf_next)) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                DROP: begin
                    if (ack) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                default: begin
                    state_d = REQ;
                    req_d   = 1'b0;
                    addr_d  = fetch_pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= REQ;
            fetch_pc_q   <= RESET_PC;
            issue_addr_q <= RESET_PC;
            instr_out    <= NOP_INSTR;
            instr_valid  <= 1'b0;
            pc_out       <= RESET_PC + PC_READ_OFS;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            issue_addr_q <= issue_addr_d;
            instr_out    <= instr_d;
            instr_valid  <= valid_d;
            pc_out       <= issue_addr_d + PC_READ_OFS;
            imem_req     <= req_d;
            imem_addr    <= addr_d;
        end
    end

`ifdef IFETCH32_BL_LINK_EN
    // Link strobe lasts exactly one cycle after a taken branch-with-link.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_we   <= 1'b0;
            link_data <= '0;
        end else begin
            link_we <= branch & bl;
            if (branch & bl) begin
                link_data <= issue_addr_q + LINK_OFS;
            end
        end
    end
`else
    logic unused_bl;
    assign unused_bl = bl;
    assign link_we   = 1'b0;
    assign link_data = '0;
`endif

endmodule

// File: tb/tb_ifetch32.sv
// Directed self-checking bench for ifetch32 with a variable-latency instruction memory.
module tb_ifetch32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr_out, pc_out, link_data;
    logic        instr_valid, link_we;
    logic        instr_ready = 1'b1;
    logic        ib = 1'b0, bl = 1'b0;
    logic [31:0] bv = '0;

    int unsigned lat = 0;
    int unsigned wait_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

`ifdef IFETCH32_BL_LINK_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'hE1A0_0000;

    ifetch32 dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .ib          (ib),
        .bv          (bv),
        .bl          (bl),
        .link_we     (link_we),
        .link_data   (link_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    // Memory acks after the request has been pending for lat cycles.
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = word_at(imem_addr);
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic rdy);
        reset = 1'b1;
        ib = 1'b0; bl = 1'b0; bv = '0; lat = 0;
        instr_ready = rdy;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fetch: req=%b addr=%h valid=%b, want 0 00000000 0", imem_req, imem_addr, instr_valid);
        end
        n_checks++;
        if (instr_out !== NOP || pc_out !== 32'h8) begin
            n_fail++;
            $display("FAIL reset_issue: instr=%h pc=%h, want %h 00000008", instr_out, pc_out, NOP);
        end
        n_checks++;
        if (link_we !== 1'b0 || link_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_link: we=%b data=%h, want 0 00000000", link_we, link_data);
        end
    endtask

    task automatic test_sequential();
        apply_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL seq_addr[%0d]: req=%b addr=%h, want 1 %h", i, imem_req, imem_addr, 32'(4 * i));
                end
            end
            n_checks++;
            if (i == 0) begin
                if (instr_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL seq_first_valid: valid=%b, want 0", instr_valid);
                end
            end else if (instr_valid !== 1'b1 || instr_out !== word_at(32'(4 * (i - 1))) ||
                         pc_out !== 32'(4 * (i - 1) + 8)) begin
                n_fail++;
                $display("FAIL seq_issue[%0d]: valid=%b instr=%h pc=%h, want 1 %h %h", i, instr_valid,
                         instr_out, pc_out, word_at(32'(4 * (i - 1))), 32'(4 * (i - 1) + 8));
            end
        end
    endtask

    task automatic test_stall();
        apply_reset(1'b0);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_out !== word_at(32'h0) || pc_out !== 32'h8) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: req=%b valid=%b instr=%h pc=%h, want 0 1 %h 00000008", k,
                         imem_req, instr_valid, instr_out, pc_out, word_at(32'h0));
            end
        end
        instr_ready = 1'b1;
        step();
        n_checks++;
        if (instr_out !== word_at(32'h4) || pc_out !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL stall_release: instr=%h pc=%h req=%b addr=%h, want %h 0000000c 1 00000008",
                     instr_out, pc_out, imem_req, imem_addr, word_at(32'h4));
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_out !== word_at(32'h8)) begin
            n_fail++;
            $display("FAIL stall_resume: valid=%b instr=%h, want 1 %h", instr_valid, instr_out, word_at(32'h8));
        end
    endtask

    task automatic test_branch();
        apply_reset(1'b1);
        step();
        step();
        ib = 1'b1; bv = 32'h0000_00F8;
        step();
        ib = 1'b0; instr_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || instr_out !== NOP || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL br_redirect: valid=%b instr=%h addr=%h req=%b, want 0 %h 00000100 1",
                     instr_valid, instr_out, imem_addr, imem_req, NOP);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_out !== word_at(32'h100) || pc_out !== 32'h108) begin
            n_fail++;
            $display("FAIL br_target: valid=%b instr=%h pc=%h, want 1 %h 00000108", instr_valid, instr_out,
                     pc_out, word_at(32'h100));
        end
        step();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL br_buffer_full: req=%b, want 0", imem_req);
        end
        instr_ready = 1'b1; ib = 1'b1; bv = 32'h0000_0020;
        step();
        ib = 1'b0;
        n_checks++;
        if (imem_addr !== 32'h128 || imem_req !== 1'b1 || instr_valid !== 1'b0 || link_we !== 1'b0) begin
            n_fail++;
            $display("FAIL br_128: addr=%h req=%b valid=%b link_we=%b, want 00000128 1 0 0", imem_addr,
                     imem_req, instr_valid, link_we);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_out !== word_at(32'h128) || pc_out !== 32'h130) begin
            n_fail++;
            $display("FAIL br_flush: valid=%b instr=%h pc=%h, want 1 %h 00000130", instr_valid, instr_out,
                     pc_out, word_at(32'h128));
        end
        step();
        n_checks++;
        if (instr_out !== word_at(32'h12C)) begin
            n_fail++;
            $display("FAIL br_next: instr=%h, want %h", instr_out, word_at(32'h12C));
        end
    endtask

    task automatic test_bl();
        apply_reset(1'b1);
        step();
        step();
        ib = 1'b1; bv = 32'h0000_01F8;
        step();
        ib = 1'b0;
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_out !== word_at(32'h200) || link_we !== 1'b0) begin
            n_fail++;
            $display("FAIL bl_setup: valid=%b instr=%h link_we=%b, want 1 %h 0", instr_valid, instr_out,
                     link_we, word_at(32'h200));
        end
        ib = 1'b1; bl = 1'b1; bv = 32'hFFFF_FFF8;
        step();
        ib = 1'b0; bl = 1'b0;
        n_checks++;
        if (link_we !== LINK_EN || link_data !== (LINK_EN ? 32'h204 : 32'h0) || imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL bl_pulse: we=%b data=%h addr=%h, want %b %h 00000200", link_we, link_data,
                     imem_addr, LINK_EN, LINK_EN ? 32'h204 : 32'h0);
        end
        step();
        n_checks++;
        if (link_we !== 1'b0 || instr_out !== word_at(32'h200) || pc_out !== 32'h208) begin
            n_fail++;
            $display("FAIL bl_after: we=%b instr=%h pc=%h, want 0 %h 00000208", link_we, instr_out, pc_out,
                     word_at(32'h200));
        end
        step();
        n_checks++;
        if (link_we !== 1'b0) begin
            n_fail++;
            $display("FAIL bl_single: we=%b, want 0", link_we);
        end
    endtask

    task automatic test_drop();
        bit seen;
        apply_reset(1'b1);
        step();
        step();
        ib = 1'b1; bv = 32'h0000_00F8;
        step();
        ib = 1'b0; instr_ready = 1'b0;
        step();
        step();
        lat = 3; instr_ready = 1'b1;
        step();
        n_checks++;
        if (instr_out !== word_at(32'h104) || pc_out !== 32'h10C || imem_req !== 1'b1 || imem_addr !== 32'h108) begin
            n_fail++;
            $display("FAIL drop_setup: instr=%h pc=%h req=%b addr=%h, want %h 0000010c 1 00000108",
                     instr_out, pc_out, imem_req, imem_addr, word_at(32'h104));
        end
        ib = 1'b1; bv = 32'h0000_0010;
        step();
        ib = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h108 || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_hold[%0d]: req=%b addr=%h valid=%b, want 1 00000108 0", k, imem_req,
                         imem_addr, instr_valid);
            end
            step();
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h11C || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_redirect: req=%b addr=%h valid=%b, want 1 0000011c 0", imem_req, imem_addr,
                     instr_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (instr_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1 || instr_out !== word_at(32'h11C) || pc_out !== 32'h124) begin
            n_fail++;
            $display("FAIL drop_target: seen=%b instr=%h pc=%h, want 1 %h 00000124", seen, instr_out, pc_out,
                     word_at(32'h11C));
        end
        lat = 0;
    endtask

    task automatic test_async_reset();
        apply_reset(1'b0);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr_out !== NOP ||
            pc_out !== 32'h8 || link_we !== 1'b0 || link_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b addr=%h valid=%b instr=%h pc=%h we=%b data=%h", imem_req,
                     imem_addr, instr_valid, instr_out, pc_out, link_we, link_data);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_bl();
        test_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
